// File: rtl/commit_collect_mpu.sv
// commit_collect_mpu
// Collects per-TPU end-of-thread pulses and turns them into an in-order commit
// stream for the MPU commit unit. Every issued thread sits in a circular table
// together with the set of TPUs still owing a completion. The thread commits
// once that set is empty and the entry is the oldest one outstanding.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   I_Req_Issue   one-cycle issue pulse from MPU dispatch
//   I_Issue_No    issue number of the issued thread
//   I_TPU_En_Exe  TPUs enabled for the issued thread
//   I_TPU_End     per-TPU completion pulses (oldest outstanding thread of that TPU)
//   O_Req_Commit  one-cycle commit pulse
//   O_CommitNo    issue number being committed, valid with O_Req_Commit
//   O_Full        table holds DEPTH entries
//   O_Empty       no outstanding entries
//   O_Count       number of outstanding entries
//   O_Err         sticky protocol error (issue while full, or unmatched end pulse)
module commit_collect_mpu #(
   parameter int unsigned NUM_TPU         = 16,
   parameter int unsigned WIDTH_ENTRY_STH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       I_Req_Issue,
   input  logic [WIDTH_ENTRY_STH-1:0] I_Issue_No,
   input  logic [NUM_TPU-1:0]         I_TPU_En_Exe,
   input  logic [NUM_TPU-1:0]         I_TPU_End,
   output logic                       O_Req_Commit,
   output logic [WIDTH_ENTRY_STH-1:0] O_CommitNo,
   output logic                       O_Full,
   output logic                       O_Empty,
   output logic [WIDTH_ENTRY_STH:0]   O_Count,
   output logic                       O_Err
);

   localparam int unsigned DEPTH = 2 ** WIDTH_ENTRY_STH;

   typedef logic [WIDTH_ENTRY_STH-1:0] ptr_t;
   typedef logic [WIDTH_ENTRY_STH:0]   cnt_t;
   typedef logic [NUM_TPU-1:0]         mask_t;

   localparam cnt_t DepthCnt = cnt_t'(DEPTH);

   // Table state
   logic [DEPTH-1:0] valid_q, valid_d;
   ptr_t             issue_no_q [DEPTH];
   ptr_t             issue_no_d [DEPTH];
   mask_t            pending_q  [DEPTH];
   mask_t            pending_d  [DEPTH];
   ptr_t             head_q, head_d;
   ptr_t             tail_q, tail_d;
   cnt_t             count_q, count_d;

   // Output registers
   logic             commit_q, commit_d;
   ptr_t             commit_no_q, commit_no_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             err_q, err_d;

   logic             pop;
   logic             issue_ok;
   logic             issue_drop;
   ptr_t             scan_idx [DEPTH];
   mask_t            end_hit;

   // Pop only on the registered pending mask so an end pulse costs one extra cycle.
   assign pop        = valid_q[head_q] && (pending_q[head_q] == '0);
   // Admission looks at the registered count only; a same-cycle pop does not help.
   assign issue_ok   = I_Req_Issue && (count_q != DepthCnt);
   assign issue_drop = I_Req_Issue && (count_q == DepthCnt);

   // Table slots in age order, oldest first.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         scan_idx[i] = head_q + ptr_t'(i);
      end
   end

   always_comb begin
      valid_d     = valid_q;
      issue_no_d  = issue_no_q;
      pending_d   = pending_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      err_d       = err_q;
      end_hit     = '0;
      commit_d    = 1'b0;
      commit_no_d = commit_no_q;

      // Each end bit clears the oldest entry still waiting on that TPU. The scan
      // uses registered state, so an entry written this cycle is never matched.
      for (int unsigned k = 0; k < NUM_TPU; k++) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (I_TPU_End[k] && !end_hit[k] && valid_q[scan_idx[i]] &&
                pending_q[scan_idx[i]][k]) begin
               pending_d[scan_idx[i]][k] = 1'b0;
               end_hit[k]                = 1'b1;
            end
         end
      end

      // The popped head has no pending bits, so it never collides with a clear.
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + ptr_t'(1);
         commit_d        = 1'b1;
         commit_no_d     = issue_no_q[head_q];
      end

      // The tail slot is free whenever issue_ok holds, so no clash with clears.
      if (issue_ok) begin
         valid_d[tail_q]    = 1'b1;
         issue_no_d[tail_q] = I_Issue_No;
         pending_d[tail_q]  = I_TPU_En_Exe;
         tail_d             = tail_q + ptr_t'(1);
      end

      case ({issue_ok, pop})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase

      if (issue_drop || ((I_TPU_End & ~end_hit) != '0)) begin
         err_d = 1'b1;
      end

      full_d  = (count_d == DepthCnt);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q     <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         commit_q    <= 1'b0;
         commit_no_q <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         err_q       <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            issue_no_q[i] <= '0;
            pending_q[i]  <= '0;
         end
      end else begin
         valid_q     <= valid_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         commit_q    <= commit_d;
         commit_no_q <= commit_no_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         err_q       <= err_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            issue_no_q[i] <= issue_no_d[i];
            pending_q[i]  <= pending_d[i];
         end
      end
   end

   assign O_Req_Commit = commit_q;
   assign O_CommitNo   = commit_no_q;
   assign O_Full       = full_q;
   assign O_Empty      = empty_q;
   assign O_Count      = count_q;
   assign O_Err        = err_q;

endmodule
